// File: rtl/spi_target.sv
// SPI mode-0 target, pins oversampled on clk (pin-to-action SYNC_STAGES+1 clks); no SPI backpressure:
// a full RX buffer drops the byte (overrun), an empty TX queue sends IDLE_BYTE. SPI_TARGET_RX_FIFO_EN selects an RX FIFO.
module spi_target #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         RX_FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_BYTE     = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_full,
  output logic [3:0] status,
  input  logic       clear_flags
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACTIVE} state_t;

  if (SYNC_STAGES < 2 || RX_FIFO_DEPTH < 1 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("spi_target: SYNC_STAGES must be >= 2 and RX_FIFO_DEPTH a power of 2");
  end

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_d, sck_d;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, sck_rise, sck_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_d      <= cs_s;
      sck_d     <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;

  state_t     state, state_nxt;
  logic       load_evt, shift_evt, sample_evt, leave_evt;
  logic       reload_pend;
  logic [2:0] bit_cnt;
  logic [6:0] shifter;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic       rx_push;
  logic [7:0] tx_buf;
  logic [7:0] load_byte;
  logic       abort_q, underrun_q, overrun_q;
  logic       abort_set, underrun_set, overrun_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_evt   = 1'b0;
    shift_evt  = 1'b0;
    sample_evt = 1'b0;
    leave_evt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_s) begin
          state_nxt = ST_IDLE;
          leave_evt = 1'b1;
        end else begin
          state_nxt = ST_ACTIVE;
          load_evt  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_s) begin
          state_nxt = ST_IDLE;
          leave_evt = 1'b1;
        end else begin
          sample_evt = sck_rise;
          // The fall that ends a byte starts the next one instead of shifting.
          if (sck_fall) begin
            load_evt  = reload_pend;
            shift_evt = ~reload_pend;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign load_byte    = tx_full ? tx_buf : IDLE_BYTE;
  assign abort_set    = leave_evt && (state == ST_ACTIVE) && (bit_cnt != 3'd0);
  assign underrun_set = load_evt && !tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      shifter     <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_byte     <= '0;
      rx_push     <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      if (leave_evt) begin
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else begin
        if (load_evt) begin
          spi_miso    <= load_byte[7];
          shifter     <= load_byte[6:0];
          spi_miso_oe <= 1'b1;
          reload_pend <= 1'b0;
          if (state == ST_LOAD) bit_cnt <= '0;
        end else if (shift_evt) begin
          spi_miso <= shifter[6];
          shifter  <= {shifter[5:0], 1'b0};
        end
        if (sample_evt) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte     <= {rx_shift, mosi_s};
            rx_push     <= 1'b1;
            reload_pend <= 1'b1;
          end
        end
      end
    end
  end

  // A load consumes the old queue state; a write landing on an empty-queue load waits for the next slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_full <= 1'b0;
      tx_buf  <= '0;
    end else if (load_evt && tx_full) begin
      tx_full <= 1'b0;
    end else if (tx_write && !tx_full) begin
      tx_buf  <= tx_data;
      tx_full <= 1'b1;
    end
  end

  logic rx_full, rx_pop, rx_accept;

  assign rx_pop      = rx_read & rx_valid;
  assign rx_accept   = rx_push & (~rx_full | rx_pop);
  assign overrun_set = rx_push & rx_full & ~rx_pop;

`ifdef SPI_TARGET_RX_FIFO_EN
  localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;

  logic [7:0]    rx_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   rx_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) rx_mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (rx_accept) begin
        rx_mem[wr_ptr] <= rx_byte;
        wr_ptr <= (wr_ptr == AW'(RX_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rx_pop) rd_ptr <= (rd_ptr == AW'(RX_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (rx_accept && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_accept && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  assign rx_data  = rx_mem[rd_ptr];
  assign rx_valid = (rx_count != '0);
  assign rx_full  = (rx_count == (AW+1)'(RX_FIFO_DEPTH));
`else
  logic [7:0] rx_hold;
  logic       rx_hold_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold     <= '0;
      rx_hold_vld <= 1'b0;
    end else if (rx_accept) begin
      rx_hold     <= rx_byte;
      rx_hold_vld <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_vld <= 1'b0;
    end
  end

  assign rx_data  = rx_hold;
  assign rx_valid = rx_hold_vld;
  assign rx_full  = rx_hold_vld;
`endif

  // Sticky flags: a set in the same cycle as clear_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      abort_q    <= abort_set    | (abort_q    & ~clear_flags);
      underrun_q <= underrun_set | (underrun_q & ~clear_flags);
      overrun_q  <= overrun_set  | (overrun_q  & ~clear_flags);
    end
  end

  assign status = {abort_q, underrun_q, overrun_q, state != ST_IDLE};

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged SPI controller, queue-based reference model, decoupled monitors.
module tb_spi_target;

  localparam int HP = 4;
`ifdef SPI_TARGET_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_read;
  logic [7:0] tx_data = 8'h00;
  logic       tx_write = 1'b0;
  logic       tx_full;
  logic [3:0] status;
  logic       clear_flags = 1'b0;
  logic       mon_read = 1'b0, man_read = 1'b0;

  assign rx_read = mon_read | man_read;

  int total = 0;
  int bad   = 0;
  bit auto_read = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] m_txq[$];
  bit m_abort = 0, m_under = 0, m_over = 0;

  logic [7:0] f_mosi[8];
  bit         f_tx_en[9];
  logic [7:0] f_tx[9];
  int         f_pop_k = -1;

  always #5 clk = ~clk;

  spi_target u_dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_read(rx_read), .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .status(status), .clear_flags(clear_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one-deep host TX queue, bounded RX buffer, sticky flags.
  function automatic logic [7:0] m_load();
    if (m_txq.size() > 0) return m_txq.pop_front();
    m_under = 1'b1;
    return 8'hFF;
  endfunction

  function automatic void m_write(input logic [7:0] b);
    if (m_txq.size() == 0) m_txq.push_back(b);
  endfunction

  function automatic void m_rx_push(input logic [7:0] b);
    if (auto_read || exp_rx.size() < CAP) exp_rx.push_back(b);
    else m_over = 1'b1;
  endfunction

  // RX monitor: drains the DUT whenever auto_read is on and compares in order.
  always @(negedge clk) begin
    if (mon_read) mon_read = 1'b0;
    else if (!rst && auto_read && rx_valid) begin
      if (exp_rx.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_unexpected: got %0h expected nothing", rx_data);
      end else check("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
      mon_read = 1'b1;
    end
  end

  // MISO monitor: collects bits on SCK rise, one comparison per whole byte.
  int         mcnt = 0;
  logic [7:0] mbuf = 8'h00;
  always @(posedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) mcnt = 0;
    else begin
      mbuf = {mbuf[6:0], spi_miso};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (exp_miso.size() == 0) begin
          total++; bad++;
          $display("FAIL miso_unexpected: got %0h expected nothing", mbuf);
        end else check("miso_byte", 32'(mbuf), 32'(exp_miso.pop_front()));
      end
    end
  end

  task automatic host_write(input logic [7:0] b);
    @(negedge clk); tx_data = b; tx_write = 1'b1; m_write(b);
    @(negedge clk); tx_write = 1'b0;
  endtask

  task automatic host_clear();
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    m_abort = 0; m_under = 0; m_over = 0;
  endtask

  task automatic check_flags(input string name);
    check(name, 32'(status[3:1]), 32'({m_abort, m_under, m_over}));
  endtask

  task automatic plan_clear();
    for (int k = 0; k < 9; k++) begin f_tx_en[k] = 1'b0; f_tx[k] = 8'h00; end
    f_pop_k = -1;
  endtask

  task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit do_tx,
                          input logic [7:0] tx_b, input bit do_pop);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (HP) @(negedge clk);
      spi_sck = 1'b1;
      for (int j = 0; j < HP; j++) begin
        @(negedge clk);
        tx_write = 1'b0;
        man_read = 1'b0;
        if (do_tx && i == 3 && j == 0) begin
          tx_data = tx_b; tx_write = 1'b1; m_write(tx_b);
        end
        if (i == 7) begin
          if (do_pop) check("pop_hold_valid", 32'(rx_valid), 32'd1);
          if (j == 1) begin
            if (do_pop) begin
              check("pop_old_data", 32'(rx_data), 32'(exp_rx[0]));
              void'(exp_rx.pop_front());
            end
            m_rx_push(mo);
          end
          if (do_pop && j == 2) man_read = 1'b1;
        end
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input int n);
    logic [7:0] cur;
    if (f_tx_en[0]) host_write(f_tx[0]);
    @(negedge clk); spi_cs_n = 1'b0;
    cur = m_load();
    repeat (8) @(negedge clk);
    check("selected", 32'(status[0]), 32'd1);
    check("miso_oe_on", 32'(spi_miso_oe), 32'd1);
    for (int k = 0; k < n; k++) begin
      exp_miso.push_back(cur);
      spi_byte(f_mosi[k], 8, f_tx_en[k+1], f_tx[k+1], k == f_pop_k);
      cur = m_load();
    end
    repeat (HP) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    plan_clear();
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Queued byte goes out, received byte held for the host.
    host_write(8'hA5);
    check("t1_tx_full_set", 32'(tx_full), 32'(m_txq.size() != 0));
    f_mosi[0] = 8'h3C;
    frame(1);
    check("t1_rx_valid", 32'(rx_valid), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'(exp_rx[0]));
    check("t1_tx_full_clr", 32'(tx_full), 32'(m_txq.size() != 0));
    check_flags("t1_flags");
    auto_read = 1'b1;
    repeat (6) @(negedge clk);
    check("t1_drained", 32'(rx_valid), 32'd0);

    // Two bytes with nothing queued.
    host_clear(); plan_clear();
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    frame(2);
    check_flags("t2_flags");

    // Deselect after five bits.
    host_clear(); plan_clear();
    auto_read = 1'b0;
    @(negedge clk); spi_cs_n = 1'b0;
    void'(m_load());
    repeat (8) @(negedge clk);
    spi_byte(8'hF0, 5, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("t3_oe_before", 32'(spi_miso_oe), 32'd1);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_oe_off", 32'(spi_miso_oe), 32'd0);
    check("t3_deselected", 32'(status[0]), 32'd0);
    m_abort = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_no_rx", 32'(rx_valid), 32'd0);
    check_flags("t3_flags");

    // Overrun without reads.
    host_clear(); plan_clear();
    for (int k = 0; k < 6; k++) f_mosi[k] = 8'(k + 1);
    frame(6);
    check_flags("t4_flags");
    check("t4_rx_valid", 32'(rx_valid), 32'd1);
    check("t4_rx_head", 32'(rx_data), 32'(exp_rx[0]));
    auto_read = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_drained", 32'(rx_valid), 32'd0);

    // Read coincident with second byte completion.
    host_clear(); plan_clear();
    auto_read = 1'b0;
    f_mosi[0] = 8'h5E; f_mosi[1] = 8'hC7; f_pop_k = 1;
    frame(2);
    check("t5_rx_valid", 32'(rx_valid), 32'd1);
    check("t5_rx_data", 32'(rx_data), 32'(exp_rx[0]));
    check_flags("t5_flags");
    auto_read = 1'b1;
    repeat (6) @(negedge clk);

    // Reset in mid-byte, then a normal frame.
    host_clear(); plan_clear();
    @(negedge clk); spi_cs_n = 1'b0;
    void'(m_load());
    repeat (8) @(negedge clk);
    spi_byte(8'h5A, 3, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_miso", 32'(spi_miso), 32'd0);
    check("t6_oe", 32'(spi_miso_oe), 32'd0);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_rx_data", 32'(rx_data), 32'd0);
    check("t6_tx_full", 32'(tx_full), 32'd0);
    check("t6_status", 32'(status), 32'd0);
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    exp_rx.delete(); exp_miso.delete(); m_txq.delete();
    m_abort = 0; m_under = 0; m_over = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    f_tx_en[0] = 1'b1; f_tx[0] = 8'hA1; f_mosi[0] = 8'h77;
    frame(1);
    check_flags("t6_after_flags");

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 1) == 1) host_clear();
      plan_clear();
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < 9; k++) begin
        f_tx_en[k] = 1'($urandom_range(0, 1));
        f_tx[k]    = 8'($urandom);
      end
      for (int k = 0; k < 8; k++) f_mosi[k] = 8'($urandom);
      frame(n);
      check_flags("rnd_flags");
      if ($urandom_range(0, 1) == 1) host_write(8'($urandom));
      check("rnd_tx_full", 32'(tx_full), 32'(m_txq.size() != 0));
    end

    repeat (20) @(negedge clk);
    check("rx_left", 32'(exp_rx.size()), 32'd0);
    check("miso_left", 32'(exp_miso.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
